signed_int_to_float_seq: RTL and testbench

- Multi-cycle converter from 32-bit two's-complement integer to IEEE-754 single precision. Inverse of the float_to_signed_int path.
- Normalizes iteratively with a shift-per-cycle loop and rounds to nearest, ties to even.
- Sits between integer datapath and FP modules behind valid/ready handshakes on both sides.

---
 rtl/signed_int_to_float_seq.sv | 123 ++++++++++++
 tb/tb_signed_int_to_float_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/signed_int_to_float_seq.sv
// Sequential 32-bit two's-complement integer to IEEE-754 single converter.
// Normalizes by up to SHIFT_STEP bits per cycle (1, 2, 4 or 8), then rounds to nearest even.
module signed_int_to_float_seq #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] signed_int_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] FP_val
);

  localparam logic [7:0] EXP_TOP = 8'd158;
  localparam logic [7:0] STEP_E  = 8'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [31:0]        fp_q;
  logic               sign_q;
  logic [31:0]        mag_q;
  logic [7:0]         exp_q;

  logic signed [31:0] op_s;
  logic [31:0]        abs_d;
  logic [31:0]        mag_d;
  logic [7:0]         exp_d;
  logic [30:0]        rnd_d;

  // Wrapping negate: -(-2^31) stays 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_val(input logic signed [31:0] v);
    logic signed [31:0] neg;
    neg = -v;
    return v[31] ? neg : v;
  endfunction

  // mag carries the hidden one in bit 31; returns {exp, mant} after round-to-nearest-even.
  function automatic logic [30:0] round_rne(input logic [30:0] mag, input logic [7:0] exp);
    logic [22:0] mant;
    logic        g;
    logic        s;
    logic        up;
    logic [23:0] sum;
    mant = mag[30:8];
    g    = mag[7];
    s    = |mag[6:0];
    up   = g & (s | mant[0]);
    sum  = {1'b0, mant} + {23'd0, up};
    if (sum[23]) return {exp + 8'd1, 23'd0};
    return {exp, sum[22:0]};
  endfunction

  always_comb begin
    op_s  = signed_int_val;
    abs_d = abs_val(op_s);
    mag_d = mag_q << 1;
    exp_d = exp_q - 8'd1;
    if (mag_q[31 -: SHIFT_STEP] == '0) begin
      mag_d = mag_q << SHIFT_STEP;
      exp_d = exp_q - STEP_E;
    end
    rnd_d = round_rne(mag_q[30:0], exp_q);
  end

  // Operand registers carry no reset: they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fp_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= op_s[31];
            mag_q      <= abs_d;
            exp_q      <= EXP_TOP;
            in_ready_q <= 1'b0;
            if (op_s == '0) begin
              fp_q        <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= mag_d;
            exp_q <= exp_d;
          end
        end
        ROUND: begin
          fp_q        <= {sign_q, rnd_d};
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign FP_val    = fp_q;

endmodule

// File: tb/tb_signed_int_to_float_seq.sv
// Bench for signed_int_to_float_seq: SHIFT_STEP=1 and SHIFT_STEP=4 instances against an arithmetic float model.
module tb_signed_int_to_float_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [31:0] signed_int_val;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] FP_val;

  logic        ir1, ov1, ir4, ov4;
  logic [31:0] fp1, fp4;

  int tests = 0;
  int fails = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  signed_int_to_float_seq #(.SHIFT_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir1),
    .signed_int_val(signed_int_val), .out_valid(ov1), .out_ready(out_ready & ~sel),
    .FP_val(fp1)
  );

  signed_int_to_float_seq #(.SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir4),
    .signed_int_val(signed_int_val), .out_valid(ov4), .out_ready(out_ready & sel),
    .FP_val(fp4)
  );

  assign in_ready  = sel ? ir4 : ir1;
  assign out_valid = sel ? ov4 : ov1;
  assign FP_val    = sel ? fp4 : fp1;

  // Reference: exact integer magnitude, position of top bit, remainder-based round-half-even.
  function automatic logic [31:0] ref_f(input logic [31:0] x);
    longint m, q, rem, half;
    int p, e, sh;
    logic s;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = 127 + p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] x, input int step);
    longint m;
    int p, lz;
    if (x == 32'd0) return 1;
    m = x[31] ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    lz = 31 - p;
    return lz / step + lz % step + 3;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Every cycle a result is presented it must equal the model's value and the input side must be closed.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected_valid got %h want none", FP_val);
      end else begin
        if (FP_val !== expq[0] || in_ready !== 1'b0) begin
          fails++;
          $display("FAIL mon_result got %h ready %b want %h ready 0", FP_val, in_ready, expq[0]);
        end
        if (out_ready === 1'b1) void'(expq.pop_front());
      end
    end
  end

  task automatic convert(input logic [31:0] x, input int stall, input bit poke,
                         output logic [31:0] got, output int lat);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid       = 1'b1;
    signed_int_val = x;
    out_ready      = 1'b0;
    expq.push_back(ref_f(x));
    @(posedge clk); #1;
    in_valid       = 1'b0;
    signed_int_val = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(ref_lat(x, sel ? 4 : 1)));
    got = FP_val;
    if (out_valid !== 1'b1) begin
      expq.delete();
      return;
    end
    if (poke) begin
      in_valid       = 1'b1;
      signed_int_val = 32'd77;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_handshake", {30'd0, in_ready, out_valid}, 32'd2);
    check("fp_held_after", FP_val, got);
  endtask

  task automatic random_run(input int count);
    logic [31:0] r, x, got;
    int lat;
    logic [31:0] corner [8] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000,
                                32'h7FFFFFFF, 32'd16777217, 32'd16777219, 32'hFEFFFFFF};
    for (int i = 0; i < count; i++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: x = r;
        1: x = r >> $urandom_range(0, 31);
        2: x = 32'd0 - (r >> $urandom_range(0, 31));
        default: x = corner[$urandom_range(0, 7)];
      endcase
      convert(x, $urandom_range(0, 3), bit'($urandom_range(0, 1)), got, lat);
    end
  endtask

  logic [31:0] dir_in  [11] = '{32'd1, 32'hFFFFFFFF, 32'd5, 32'd0, 32'h80000000, 32'h7FFFFFFF,
                               32'd16777217, 32'd16777219, 32'd16777221, 32'hFEFFFFFF, 32'd3};
  logic [31:0] dir_out [11] = '{32'h3F800000, 32'hBF800000, 32'h40A00000, 32'h00000000,
                               32'hCF000000, 32'h4F000000, 32'h4B800000, 32'h4B800002,
                               32'h4B800002, 32'hCB800000, 32'h40400000};

  initial begin
    #1_500_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int lat;
    sel            = 1'b0;
    rst            = 1'b1;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    signed_int_val = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", {in_ready, out_valid, FP_val[29:0]}, 32'h80000000);
    check("reset_fp", FP_val, 32'd0);

    for (int i = 0; i < 11; i++) check($sformatf("model_%0d", i), ref_f(dir_in[i]), dir_out[i]);

    for (int i = 0; i < 11; i++) begin
      convert(dir_in[i], 0, 1'b0, got, lat);
      check($sformatf("dut1_%h", dir_in[i]), got, dir_out[i]);
      if (i == 0) check("lat_one", 32'(lat), 32'd34);
      if (i == 3) check("lat_zero", 32'(lat), 32'd1);
      if (i == 4) check("lat_min", 32'(lat), 32'd3);
    end

    convert(32'd5, 10, 1'b1, got, lat);
    check("backpressure_val", got, 32'h40A00000);

    // Abort a conversion of 1 in its tenth cycle.
    in_valid       = 1'b1;
    signed_int_val = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midop_reset", {in_ready, out_valid, FP_val[29:0]}, 32'h80000000);
    check("midop_reset_fp", FP_val, 32'd0);
    convert(32'd3, 0, 1'b0, got, lat);
    check("after_reset_3", got, 32'h40400000);

    random_run(1000);

    sel = 1'b1;
    @(posedge clk); #1;
    convert(32'd1, 0, 1'b0, got, lat);
    check("dut4_one", got, 32'h3F800000);
    check("dut4_lat_one", 32'(lat), 32'd13);
    convert(32'h7FFFFFFF, 2, 1'b1, got, lat);
    check("dut4_max", got, 32'h4F000000);
    convert(32'd16777219, 0, 1'b0, got, lat);
    check("dut4_tie", got, 32'h4B800002);
    random_run(1000);

    check("queue_drained", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
